htif_mbox: RTL and testbench
============================

# htif_mbox

Synthesizable host-interface mailbox that snoops the SRAM0 write port inside `cpu_wrap` and decodes riscv-tests style `tohost` writes. An `arg` word at `tohost` followed by a `cmd` word at `tohost+1` becomes either a console character, drained through a valid/ready byte stream towards the UART path, or a sticky exit indication carrying the end code. After dispatch, the block clears both mailbox words back to zero through a request/acknowledge write port into SRAM0.

## Interface
- `ADDR_W`, 14: SRAM word-address width.
- `FIFO_DEPTH`, 8: character FIFO entries; power of two, ≥2.
- `clk` input 1: the only clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `tohost_addr` input ADDR_W: word index of `arg`. `cmd` is at `tohost_addr+1`. Must be stable whenever `rstn` is high.
- `mem_cs` input 1: snooped SRAM chip select.
- `mem_we` input 1: snooped SRAM write enable.
- `mem_a` input ADDR_W: snooped word address.
- `mem_di` input 32: snooped write data.
- `chr_valid` output 1: FIFO head valid.
- `chr_data` output 8: FIFO head byte.
- `chr_ready` input 1: consumer accepts the head byte.
- `exit_valid` output 1: sticky; an exit command has been seen.
- `exit_code` output 32: `arg` of the exit command.
- `clr_req` output 1: mailbox clear-write request.
- `clr_addr` output ADDR_W: word to clear.
- `clr_ack` input 1: clear write performed this cycle.
- `unk_cmd` output 1: one-cycle pulse for an unrecognised `cmd`.
- `ovf` output 1: sticky; a character was dropped because the FIFO was full.

## Operation
- A snooped write is a cycle with `mem_cs & mem_we`. Only a write to `tohost_addr` (arg hit) or to `tohost_addr+1` (cmd hit) is relevant. The address add wraps modulo 2^ADDR_W.
- FSM states: IDLE, ARG, DISP, CLR0, CLR1, HALT.
  - IDLE: arg hit → latch `arg=mem_di`, go to ARG. A cmd hit in IDLE is ignored.
  - ARG: another arg hit → overwrite `arg`, stay in ARG. Cmd hit → latch `cmd=mem_di`, go to DISP.
  - DISP (exactly 1 cycle), decode `cmd`:
    - `32'h0000_0000`: set `exit_valid`, `exit_code=arg`.
    - `32'h0101_0000`: push `arg[7:0]` into the FIFO. If the FIFO is full and not popping this cycle, drop the byte and set `ovf`.
    - Any other value: pulse `unk_cmd`.
    - In all cases, go to CLR0.
  - CLR0: drive `clr_req=1`, `clr_addr=tohost_addr`. On `clr_ack`, go to CLR1.
  - CLR1: drive `clr_req=1`, `clr_addr=tohost_addr+1`. On `clr_ack`, go to HALT if `exit_valid`, else IDLE.
  - HALT: terminal state; all snooped writes are ignored until reset.
- Snooped writes in DISP, CLR0 and CLR1 are ignored; the mailbox is owned by the clear sequence.
- FIFO behaviour:
  - A pop occurs on `chr_valid & chr_ready`.
  - A push and a pop in the same cycle both occur. Pushing into a full FIFO succeeds if a pop happens in the same cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits. Full is when the MSBs differ and the rest are equal.
- The FIFO keeps draining in every state, including HALT.

## Timing
- Reset values: `chr_valid=0`, `chr_data=0`, `exit_valid=0`, `exit_code=0`, `clr_req=0`, `clr_addr=0`, `unk_cmd=0`, `ovf=0`. Internal state: FSM in IDLE, `arg=0`, `cmd=0`, FIFO empty.
- Cmd hit at edge N → DISP during cycle N+1 → at N+2: `chr_valid`/`exit_valid` visible, `unk_cmd` high for that one cycle, and `clr_req` high.
- `clr_req` and `clr_addr` are registered, and hold until `clr_ack`. Two clears with zero-wait acknowledge take 2 cycles.
- `clr_ack` while `clr_req=0` is ignored.
- `chr_data` is registered and valid whenever `chr_valid` is high; it must not change while `chr_valid & ~chr_ready`.
- Asserting `rstn` low at any point returns everything to the reset values immediately, including a pending `clr_req` and FIFO contents.

## Structure
- Package `htif_pkg`:
  - command constants `HTIF_CMD_EXIT=32'h0`, `HTIF_CMD_PUTC=32'h0101_0000`;
  - state enum `htif_state_e`.
- Sub-module `htif_fifo`: parameterised depth/width synchronous FIFO with push/pop/full/empty and a registered head. It is instantiated with width 8.

## Test plan
- `tohost_addr=14'h400`. Write 0x41 to 0x400, then 0x0101_0000 to 0x401 → `chr_valid` with `chr_data=8'h41` 2 cycles after the cmd write. Clears go to 0x400 then 0x401. FSM returns to IDLE.
- Write 0xDEAD to 0x400, then 0 to 0x401 → `exit_valid=1`, `exit_code=32'h0000_DEAD`. After both clears the FSM is in HALT, and a later putc sequence produces no `chr_valid`.
- `chr_ready=0`, send 9 putc commands (0x30..0x38) with `FIFO_DEPTH=8` → `ovf=1` and 0x38 is dropped. Then `chr_ready=1` drains exactly 0x30..0x37 in order.
- Write 0x400 twice (0x11, then 0x22), then cmd putc → output byte is 0x22. A cmd-only write to 0x401 from IDLE produces nothing.
- `cmd=32'h5` → `unk_cmd` high for exactly one cycle, no char, no exit, clears still issued. Hold `clr_ack=0` for 5 cycles → `clr_req` and `clr_addr=0x400` held stable throughout.
- `tohost_addr=14'hc00` with `rstn` pulsed low while in CLR0 → all outputs return to reset values. A fresh putc sequence at 0xc00/0xc01 works normally.

Source files
------------

// File: rtl/htif_pkg.sv
// htif_pkg: shared HTIF mailbox command codes and FSM state encoding.
package htif_pkg;
   localparam logic [31:0] HTIF_CMD_EXIT = 32'h0000_0000;
   localparam logic [31:0] HTIF_CMD_PUTC = 32'h0101_0000;
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARG  = 3'd1,
      S_DISP = 3'd2,
      S_CLR0 = 3'd3,
      S_CLR1 = 3'd4,
      S_HALT = 3'd5
   } htif_state_e;
endpackage

// File: rtl/htif_fifo.sv
// htif_fifo: synchronous FIFO with a registered head word.
//   clk, rstn    : clock, async active-low reset (empties the FIFO)
//   push, din    : write request and data (ignored when full unless popping)
//   pop          : read request (ignored when empty)
//   full, empty  : occupancy flags
//   head         : registered copy of the oldest entry, valid when ~empty
module htif_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wp, rp, wp_n, rp_n;
   logic do_push, do_pop;
   assign empty   = wp == rp;
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign wp_n    = wp + (AW+1)'(do_push);
   assign rp_n    = rp + (AW+1)'(do_pop);
   always_ff @(posedge clk)
      if (do_push) mem[wp[AW-1:0]] <= din;
   // The head is recomputed from the post-update pointers; when the new read
   // pointer lands on the slot being written this cycle, bypass din.
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         wp   <= '0;
         rp   <= '0;
         head <= '0;
      end else begin
         wp   <= wp_n;
         rp   <= rp_n;
         head <= (rp_n == wp) ? din : mem[rp_n[AW-1:0]];
      end
endmodule

// File: rtl/htif_mbox.sv
// htif_mbox: snoops SRAM writes for riscv-tests tohost/cmd, emits console
// characters or a sticky exit, then clears both mailbox words.
//   clk, rstn                 : clock, async active-low reset
//   tohost_addr               : word address of arg (cmd lives at +1)
//   mem_cs/mem_we/mem_a/mem_di: snooped SRAM write port
//   chr_valid/chr_data/chr_ready : console byte stream (FIFO head)
//   exit_valid/exit_code      : sticky exit indication and its code
//   clr_req/clr_addr/clr_ack  : mailbox clear-write handshake
//   unk_cmd                   : one-cycle pulse on an unrecognised cmd
//   ovf                       : sticky, a character was dropped on a full FIFO
module htif_mbox
   import htif_pkg::*;
#(
   parameter int ADDR_W     = 14,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] tohost_addr,
   input  logic              mem_cs,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_a,
   input  logic [31:0]       mem_di,
   output logic              chr_valid,
   output logic [7:0]        chr_data,
   input  logic              chr_ready,
   output logic              exit_valid,
   output logic [31:0]       exit_code,
   output logic              clr_req,
   output logic [ADDR_W-1:0] clr_addr,
   input  logic              clr_ack,
   output logic              unk_cmd,
   output logic              ovf
);
   htif_state_e state;
   logic [31:0] arg, cmd;
   logic [ADDR_W-1:0] cmd_addr;
   logic wr, arg_hit, cmd_hit, put, pop, full, empty;
   assign cmd_addr  = tohost_addr + ADDR_W'(1);
   assign wr        = mem_cs & mem_we;
   assign arg_hit   = wr && (mem_a == tohost_addr);
   assign cmd_hit   = wr && (mem_a == cmd_addr);
   assign put       = (state == S_DISP) && (cmd == HTIF_CMD_PUTC);
   assign chr_valid = ~empty;
   assign pop       = chr_valid & chr_ready;
   htif_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (put),
      .din   (arg[7:0]),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (chr_data)
   );
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state      <= S_IDLE;
         arg        <= '0;
         cmd        <= '0;
         exit_valid <= 1'b0;
         exit_code  <= '0;
         clr_req    <= 1'b0;
         clr_addr   <= '0;
         unk_cmd    <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         unk_cmd <= (state == S_DISP) && (cmd != HTIF_CMD_EXIT) && (cmd != HTIF_CMD_PUTC);
         if (put && full && !pop) ovf <= 1'b1;
         case (state)
            S_IDLE:
               if (arg_hit) begin
                  arg   <= mem_di;
                  state <= S_ARG;
               end
            S_ARG:
               if (arg_hit) arg <= mem_di;
               else if (cmd_hit) begin
                  cmd   <= mem_di;
                  state <= S_DISP;
               end
            S_DISP: begin
               if (cmd == HTIF_CMD_EXIT) begin
                  exit_valid <= 1'b1;
                  exit_code  <= arg;
               end
               clr_req  <= 1'b1;
               clr_addr <= tohost_addr;
               state    <= S_CLR0;
            end
            S_CLR0:
               if (clr_ack) begin
                  clr_addr <= cmd_addr;
                  state    <= S_CLR1;
               end
            S_CLR1:
               if (clr_ack) begin
                  clr_req <= 1'b0;
                  state   <= exit_valid ? S_HALT : S_IDLE;
               end
            default: state <= S_HALT;
         endcase
      end
endmodule

// File: tb/tb_htif_mbox.sv
// tb_htif_mbox: scoreboard bench for the HTIF mailbox.
module tb_htif_mbox;
   localparam logic [31:0] PUTC = 32'h0101_0000;
   logic        clk = 1'b0, rstn = 1'b0;
   logic [13:0] tohost_addr = 14'h400;
   logic        mem_cs = 1'b0, mem_we = 1'b0;
   logic [13:0] mem_a = '0;
   logic [31:0] mem_di = '0;
   logic        chr_valid, chr_ready = 1'b0;
   logic [7:0]  chr_data;
   logic        exit_valid;
   logic [31:0] exit_code;
   logic        clr_req, clr_ack = 1'b0;
   logic [13:0] clr_addr;
   logic        unk_cmd, ovf;
   int checks = 0, errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_e;

   htif_mbox #(.ADDR_W(14), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rstn(rstn), .tohost_addr(tohost_addr),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_a(mem_a), .mem_di(mem_di),
      .chr_valid(chr_valid), .chr_data(chr_data), .chr_ready(chr_ready),
      .exit_valid(exit_valid), .exit_code(exit_code),
      .clr_req(clr_req), .clr_addr(clr_addr), .clr_ack(clr_ack),
      .unk_cmd(unk_cmd), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // consumer side: every accepted byte must match the scoreboard head
   always @(negedge clk)
      if (rstn && chr_valid && chr_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL chr_unexpected got %h required none", chr_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (chr_data !== mon_e) begin
               errors++;
               $display("FAIL chr_data got %h required %h", chr_data, mon_e);
            end
         end
      end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [13:0] a, input logic [31:0] d);
      mem_cs = 1'b1; mem_we = 1'b1; mem_a = a; mem_di = d;
      tick();
      mem_cs = 1'b0; mem_we = 1'b0;
   endtask

   // arg + cmd then the three cycles DISP/CLR0/CLR1 with clr_ack held high
   task automatic send(input logic [13:0] base, input logic [31:0] a, input logic [31:0] c);
      wr(base, a);
      wr(base + 14'd1, c);
      repeat (3) tick();
      checks++;
      if (clr_req !== 1'b0) begin
         errors++;
         $display("FAIL send_clr_done got %b required 0", clr_req);
      end
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({chr_valid, chr_data, exit_valid, exit_code, clr_req, clr_addr, unk_cmd, ovf} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b/%h/%b/%h/%b/%h/%b/%b required all 0",
                  chr_valid, chr_data, exit_valid, exit_code, clr_req, clr_addr, unk_cmd, ovf);
      end
      tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_putc;
      chr_ready = 1'b0; clr_ack = 1'b0;
      wr(14'h400, 32'h41);
      wr(14'h401, PUTC);
      checks++;
      if ({chr_valid, clr_req} !== 2'b00) begin
         errors++;
         $display("FAIL putc_disp got %b%b required 00", chr_valid, clr_req);
      end
      tick();
      checks++;
      if ({chr_valid, chr_data} !== {1'b1, 8'h41}) begin
         errors++;
         $display("FAIL putc_char got %b/%h required 1/41", chr_valid, chr_data);
      end
      checks++;
      if ({clr_req, clr_addr} !== {1'b1, 14'h400}) begin
         errors++;
         $display("FAIL putc_clr0 got %b/%h required 1/400", clr_req, clr_addr);
      end
      clr_ack = 1'b1;
      tick();
      checks++;
      if ({clr_req, clr_addr} !== {1'b1, 14'h401}) begin
         errors++;
         $display("FAIL putc_clr1 got %b/%h required 1/401", clr_req, clr_addr);
      end
      tick();
      checks++;
      if (clr_req !== 1'b0) begin
         errors++;
         $display("FAIL putc_clr_done got %b required 0", clr_req);
      end
      exp_q.push_back(8'h41);
      chr_ready = 1'b1;
      repeat (2) tick();
      checks++;
      if (chr_valid !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL putc_drain got valid=%b left=%0d required 0/0", chr_valid, exp_q.size());
      end
   endtask

   task automatic test_overflow;
      chr_ready = 1'b0; clr_ack = 1'b1;
      for (int i = 0; i < 8; i++) send(14'h400, 32'h30 + i, PUTC);
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_at_full got %b required 0", ovf);
      end
      send(14'h400, 32'h38, PUTC);
      checks++;
      if ({ovf, chr_data} !== {1'b1, 8'h30}) begin
         errors++;
         $display("FAIL ovf_drop got %b/%h required 1/30", ovf, chr_data);
      end
      for (int i = 0; i < 8; i++) exp_q.push_back(8'h30 + 8'(i));
      chr_ready = 1'b1;
      repeat (12) tick();
      checks++;
      if (chr_valid !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL ovf_drain got valid=%b left=%0d required 0/0", chr_valid, exp_q.size());
      end
   endtask

   task automatic test_overwrite;
      chr_ready = 1'b1; clr_ack = 1'b1;
      wr(14'h400, 32'h11);
      wr(14'h400, 32'h22);
      exp_q.push_back(8'h22);
      wr(14'h401, PUTC);
      repeat (4) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL overwrite_seen got left=%0d required 0", exp_q.size());
      end
      wr(14'h401, PUTC);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({chr_valid, clr_req} !== 2'b00) begin
            errors++;
            $display("FAIL cmd_only got %b%b required 00", chr_valid, clr_req);
         end
      end
   endtask

   task automatic test_unknown;
      chr_ready = 1'b1; clr_ack = 1'b0;
      wr(14'h400, 32'h7);
      wr(14'h401, 32'h5);
      tick();
      checks++;
      if ({unk_cmd, chr_valid, exit_valid} !== 3'b100) begin
         errors++;
         $display("FAIL unk_pulse got %b%b%b required 100", unk_cmd, chr_valid, exit_valid);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({clr_req, clr_addr} !== {1'b1, 14'h400}) begin
            errors++;
            $display("FAIL unk_hold got %b/%h required 1/400", clr_req, clr_addr);
         end
         tick();
         if (i == 0) begin
            checks++;
            if (unk_cmd !== 1'b0) begin
               errors++;
               $display("FAIL unk_one_cycle got %b required 0", unk_cmd);
            end
         end
      end
      clr_ack = 1'b1;
      tick();
      checks++;
      if ({clr_req, clr_addr} !== {1'b1, 14'h401}) begin
         errors++;
         $display("FAIL unk_clr1 got %b/%h required 1/401", clr_req, clr_addr);
      end
      tick();
      checks++;
      if (clr_req !== 1'b0) begin
         errors++;
         $display("FAIL unk_clr_done got %b required 0", clr_req);
      end
   endtask

   task automatic test_exit;
      chr_ready = 1'b1; clr_ack = 1'b1;
      wr(14'h400, 32'hDEAD);
      wr(14'h401, 32'h0);
      tick();
      checks++;
      if ({exit_valid, exit_code, chr_valid} !== {1'b1, 32'h0000_DEAD, 1'b0}) begin
         errors++;
         $display("FAIL exit got %b/%h/%b required 1/0000dead/0", exit_valid, exit_code, chr_valid);
      end
      repeat (2) tick();
      send(14'h400, 32'h42, PUTC);
      tick();
      checks++;
      if ({chr_valid, exit_valid, exit_code} !== {1'b0, 1'b1, 32'h0000_DEAD}) begin
         errors++;
         $display("FAIL halt got %b/%b/%h required 0/1/0000dead", chr_valid, exit_valid, exit_code);
      end
   endtask

   task automatic test_reset_mid;
      rstn = 1'b0;
      tick();
      tohost_addr = 14'hc00;
      rstn = 1'b1;
      tick();
      chr_ready = 1'b0; clr_ack = 1'b0;
      wr(14'hc00, 32'h55);
      wr(14'hc01, PUTC);
      tick();
      checks++;
      if ({clr_req, clr_addr, chr_valid} !== {1'b1, 14'hc00, 1'b1}) begin
         errors++;
         $display("FAIL mid_clr0 got %b/%h/%b required 1/c00/1", clr_req, clr_addr, chr_valid);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({chr_valid, chr_data, exit_valid, exit_code, clr_req, clr_addr, unk_cmd, ovf} !== '0) begin
         errors++;
         $display("FAIL mid_reset got %b/%h/%b/%h/%b/%h/%b/%b required all 0",
                  chr_valid, chr_data, exit_valid, exit_code, clr_req, clr_addr, unk_cmd, ovf);
      end
      tick();
      rstn = 1'b1;
      chr_ready = 1'b1; clr_ack = 1'b1;
      tick();
      wr(14'hc00, 32'h5A);
      exp_q.push_back(8'h5A);
      wr(14'hc01, PUTC);
      tick();
      checks++;
      if ({clr_req, clr_addr} !== {1'b1, 14'hc00}) begin
         errors++;
         $display("FAIL fresh_clr0 got %b/%h required 1/c00", clr_req, clr_addr);
      end
      tick();
      checks++;
      if ({clr_req, clr_addr} !== {1'b1, 14'hc01}) begin
         errors++;
         $display("FAIL fresh_clr1 got %b/%h required 1/c01", clr_req, clr_addr);
      end
      repeat (2) tick();
      checks++;
      if (clr_req !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL fresh_done got clr=%b left=%0d required 0/0", clr_req, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_putc();
      test_overflow();
      test_overwrite();
      test_unknown();
      test_exit();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
